// File: rtl/stream_capture.sv
// Versat stream capture unit: writes the in0 stream into a local RAM along a two-level
// address pattern and serves CPU reads. Optional macro STREAM_CAPTURE_ACCUM_EN adds accumulate mode.
module stream_capture #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  input  logic [31:0]       delay0,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W-1:0] incr,
  input  logic [ADDR_W-1:0] shift,
  input  logic [9:0]        period,
  input  logic [9:0]        iterations,
`ifdef STREAM_CAPTURE_ACCUM_EN
  input  logic              accum,
`endif
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state_r;
  logic [31:0]       delay_cnt_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [ADDR_W-1:0] incr_r;
  logic [ADDR_W-1:0] shift_r;
  logic [9:0]        period_r;
  logic [9:0]        iter_r;
  logic [9:0]        pcnt_r;
  logic [9:0]        icnt_r;
  logic              accum_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              wr_en_s;
  logic [DATA_W-1:0] wdata_s;
  logic              period_end_s;
  logic              iter_end_s;

  // Write strobe and end-of-loop detection; a reset cycle suppresses the pending write
  always_comb begin
    wr_en_s      = (state_r == WRITE) && !rst;
    period_end_s = (pcnt_r == period_r - 10'd1);
    iter_end_s   = (icnt_r == iter_r - 10'd1);
  end

  // Write data; the RAM is read asynchronously so back-to-back hits on one address see the previous sum
  always_comb begin
    wdata_s = in0;
`ifdef STREAM_CAPTURE_ACCUM_EN
    if (accum_r) begin
      wdata_s = mem_r[waddr_r] + in0;
    end else begin
      wdata_s = in0;
    end
`endif
  end

  // Control FSM: config latching, start delay, address generation and done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      done        <= 1'b1;
      delay_cnt_r <= 32'd0;
      waddr_r     <= '0;
      incr_r      <= '0;
      shift_r     <= '0;
      period_r    <= 10'd0;
      iter_r      <= 10'd0;
      pcnt_r      <= 10'd0;
      icnt_r      <= 10'd0;
      accum_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b1;
          if (run) begin
            waddr_r     <= start;
            incr_r      <= incr;
            shift_r     <= shift;
            period_r    <= period;
            iter_r      <= iterations;
            pcnt_r      <= 10'd0;
            icnt_r      <= 10'd0;
            delay_cnt_r <= delay0;
`ifdef STREAM_CAPTURE_ACCUM_EN
            accum_r     <= accum;
`else
            accum_r     <= 1'b0;
`endif
            // An empty run never leaves IDLE, so done stays high
            if ((iterations == 10'd0) || (period == 10'd0)) begin
              state_r <= IDLE;
            end else if (delay0 == 32'd0) begin
              state_r <= WRITE;
              done    <= 1'b0;
            end else begin
              state_r <= DELAY;
              done    <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DELAY: begin
          if (delay_cnt_r == 32'd1) begin
            state_r <= WRITE;
          end else begin
            delay_cnt_r <= delay_cnt_r - 32'd1;
          end
        end
        WRITE: begin
          if (period_end_s) begin
            pcnt_r  <= 10'd0;
            waddr_r <= waddr_r + incr_r + shift_r;
            if (iter_end_s) begin
              state_r <= IDLE;
              done    <= 1'b1;
            end else begin
              icnt_r <= icnt_r + 10'd1;
            end
          end else begin
            pcnt_r  <= pcnt_r + 10'd1;
            waddr_r <= waddr_r + incr_r;
          end
        end
        default: begin
          state_r <= IDLE;
          done    <= 1'b1;
        end
      endcase
    end
  end

  // Capture RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[waddr_r] <= wdata_s;
    end
  end

  // CPU read port; a same-cycle stream write to the same word is not visible yet
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      if (valid) begin
        rdata <= mem_r[addr];
      end
    end
  end

endmodule

// File: tb/tb_stream_capture.sv
// Scoreboard bench for stream_capture: a queue-based reference model predicts RAM contents,
// done timing and read data; a separate monitor checks each read response.
module tb_stream_capture;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, run, valid, accum;
  logic [DW-1:0] in0;
  logic [31:0]   delay0;
  logic [AW-1:0] start, incr, shift, addr;
  logic [9:0]    period, iterations;
  logic          done, ready;
  logic [DW-1:0] rdata;

  stream_capture #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .in0(in0), .delay0(delay0),
    .start(start), .incr(incr), .shift(shift), .period(period), .iterations(iterations),
`ifdef STREAM_CAPTURE_ACCUM_EN
    .accum(accum),
`endif
    .valid(valid), .addr(addr), .ready(ready), .rdata(rdata)
  );

  int            cyc = 0;
  int            busy_end = -1;
  int            first_wr = 0;
  int            wr_q[$];
  logic [DW-1:0] ref_mem [1024];
  bit            known [1024];
  int            known_list[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rd_model = '0;
  bit            acc_m = 1'b0;
  bit            chk_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  task automatic fail(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    failures++;
    $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  // One clock cycle: check outputs of this cycle, advance the reference model, wait a cycle.
  task automatic tick();
    logic exp_done;
    int a, n;
    if (chk_en) begin
      exp_done = (cyc > busy_end);
      checks++;
      if (done !== exp_done) fail("done", {31'd0, done}, {31'd0, exp_done});
      checks++;
      if (rdata !== rd_model) fail("rdata_hold", rdata, rd_model);
    end
    if (rst) begin
      wr_q.delete();
      if (busy_end > cyc) busy_end = cyc;
      rd_model = '0;
    end else begin
      if (valid) begin
        exp_q.push_back(ref_mem[addr]);
        rd_model = ref_mem[addr];
      end
      if (wr_q.size() > 0 && cyc >= first_wr) begin
        a = wr_q.pop_front();
        ref_mem[a] = acc_m ? ref_mem[a] + in0 : in0;
        if (!known[a]) begin
          known[a] = 1'b1;
          known_list.push_back(a);
        end
      end
      if (run && cyc > busy_end) begin
        n = int'(iterations) * int'(period);
        if (n > 0) begin
          acc_m = accum;
          a = int'(start);
          for (int i = 0; i < int'(iterations); i++) begin
            for (int p = 0; p < int'(period); p++) begin
              wr_q.push_back(a);
              a = (a + int'(incr) + ((p == int'(period) - 1) ? int'(shift) : 0)) & 1023;
            end
          end
          first_wr = cyc + 1 + int'(delay0);
          busy_end = cyc + int'(delay0) + n;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    run = 1'b0; valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in0 = $urandom;
      tick();
    end
  endtask

  task automatic launch(input int s, input int inc, input int sh, input int per,
                        input int it, input int dly, input bit acc);
    start = AW'(s); incr = AW'(inc); shift = AW'(sh);
    period = 10'(per); iterations = 10'(it); delay0 = 32'(dly); accum = acc;
    run = 1'b1; valid = 1'b0; in0 = $urandom;
    tick();
    run = 1'b0;
  endtask

  // Run until the model says the unit is idle; config is scrambled and optional
  // extra run pulses / random reads are issued while busy.
  task automatic finish_run(input bit busy_runs, input bit rand_reads);
    for (int i = 0; i < 2000 && cyc <= busy_end; i++) begin
      in0 = $urandom;
      start = AW'($urandom); incr = AW'($urandom); shift = AW'($urandom);
      period = 10'($urandom_range(1, 5)); iterations = 10'($urandom_range(1, 5));
      delay0 = $urandom_range(0, 4); accum = 1'($urandom);
      run = busy_runs ? ($urandom_range(0, 3) == 0) : 1'b0;
      valid = 1'b0;
      if (rand_reads && known_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        valid = 1'b1;
        addr = AW'(known_list[$urandom_range(0, known_list.size() - 1)]);
      end
      tick();
    end
    run = 1'b0; valid = 1'b0;
  endtask

  task automatic read_range(input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      if (known[(lo + i) & 1023]) begin
        valid = 1'b1;
        addr = AW'((lo + i) & 1023);
        in0 = $urandom;
        tick();
      end
    end
    valid = 1'b0;
    idle(2);
  endtask

  // Monitor: every read response is matched against the oldest pending expectation.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (chk_en && ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fail("read_unexpected", rdata, '0);
      end else begin
        e = exp_q.pop_front();
        if (rdata !== e) fail("read_data", rdata, e);
      end
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; valid = 1'b0; accum = 1'b0; in0 = '0; addr = '0;
    delay0 = 32'd0; start = '0; incr = '0; shift = '0; period = 10'd0; iterations = 10'd0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b0) fail("reset_ready", {31'd0, ready}, '0);
    checks++;
    if (rdata !== '0) fail("reset_rdata", rdata, '0);
    idle(2);

    // Basic capture, then read back
    launch(0, 1, 0, 4, 2, 0, 1'b0);
    finish_run(1'b0, 1'b0);
    read_range(0, 8);

    // Delay and shift
    launch(16, 2, 5, 3, 2, 3, 1'b0);
    finish_run(1'b0, 1'b0);
    read_range(16, 16);

    // Address wrap, then an empty run that must leave RAM untouched
    launch(1022, 1, 0, 4, 1, 0, 1'b0);
    finish_run(1'b0, 1'b0);
    launch(200, 1, 0, 4, 0, 2, 1'b0);
    idle(3);
    launch(200, 1, 0, 0, 3, 0, 1'b0);
    idle(3);
    read_range(1020, 6);

    // Run pulses while busy are ignored
    launch(40, 3, -2, 4, 3, 2, 1'b0);
    finish_run(1'b1, 1'b0);
    read_range(40, 24);

    // Reset on write 2 of 8 keeps only writes 0..1
    launch(96, 1, 0, 16, 1, 0, 1'b0);
    finish_run(1'b0, 1'b0);
    launch(100, 1, 0, 8, 1, 0, 1'b0);
    idle(2);
    rst = 1'b1;
    in0 = $urandom;
    tick();
    rst = 1'b0;
    idle(2);
    read_range(96, 16);
    launch(100, 1, 0, 8, 1, 1, 1'b0);
    finish_run(1'b0, 1'b0);
    read_range(96, 16);

    // Read/write collision on address 5
    launch(0, 1, 0, 8, 1, 0, 1'b0);
    idle(5);
    valid = 1'b1; addr = AW'(5); in0 = $urandom;
    tick();
    in0 = $urandom;
    tick();
    valid = 1'b0;
    finish_run(1'b0, 1'b0);
    read_range(4, 3);

    // Randomized runs with interleaved reads and scrambled config
    for (int r = 0; r < 8; r++) begin
      launch($urandom_range(0, 1023), $urandom_range(0, 3) - 1, $urandom_range(0, 6) - 3,
             $urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
      finish_run(1'b1, 1'b1);
      idle(1);
    end

`ifdef STREAM_CAPTURE_ACCUM_EN
    // Accumulate into a single address across consecutive cycles
    launch(3, 0, 0, 1, 1, 0, 1'b0);
    in0 = 32'd10; run = 1'b0; tick();
    idle(1);
    launch(3, 0, 0, 4, 1, 0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      in0 = 32'(k);
      tick();
    end
    idle(1);
    checks++;
    if (ref_mem[3] !== 32'd20) fail("accum_model", ref_mem[3], 32'd20);
    read_range(3, 1);
`endif

    idle(3);
    checks++;
    if (exp_q.size() != 0) fail("reads_missing", 32'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
